// File: rtl/arb_1r1w_pkg.sv
// Shared types and helpers for the 1R1W multi-client arbiter front-end.
package arb_1r1w_pkg;

    // Client ids are carried in a fixed-width field large enough for 16 clients.
    localparam int MAX_CLI_BITS = 4;

    // One entry of the read-tag pipeline: was a read issued, and for whom.
    typedef struct packed {
        logic                    vld;
        logic [MAX_CLI_BITS-1:0] id;
    } tag_t;

    // Number of bits needed to index n clients (never less than 1).
    function automatic int cli_bits(input int n);
        int b;
        b = 1;
        while ((1 << b) < n) begin
            b = b + 1;
        end
        return b;
    endfunction

endpackage

// File: rtl/arb_1r1w_a1_if.sv
// Client-side and core-side bus of the 1R1W arbiter front-end.
interface arb_1r1w_a1_if #(
    parameter int WIDTH   = 32,
    parameter int BITADDR = 13,
    parameter int NUMRCLI = 4,
    parameter int NUMWCLI = 2
);
    // Read clients
    logic [NUMRCLI-1:0]         rreq_vld;
    logic [NUMRCLI*BITADDR-1:0] rreq_addr;
    logic [NUMRCLI-1:0]         rreq_rdy;
    logic [NUMRCLI-1:0]         rrsp_vld;
    logic [WIDTH-1:0]           rrsp_data;
    logic                       rrsp_err;
    // Write clients
    logic [NUMWCLI-1:0]         wreq_vld;
    logic [NUMWCLI*BITADDR-1:0] wreq_addr;
    logic [NUMWCLI*WIDTH-1:0]   wreq_data;
    logic [NUMWCLI-1:0]         wreq_rdy;
    // Core request side
    logic                       vread;
    logic [BITADDR-1:0]         vrdaddr;
    logic                       vwrite;
    logic [BITADDR-1:0]         vwraddr;
    logic [WIDTH-1:0]           vdin;
    // Core response side
    logic                       vread_vld;
    logic [WIDTH-1:0]           vdout;
    logic                       vread_err;
    logic                       ready;
    // Status
    logic                       seq_err;

    // Arbiter view
    modport slave (
        input  rreq_vld, rreq_addr, wreq_vld, wreq_addr, wreq_data,
        input  vread_vld, vdout, vread_err, ready,
        output rreq_rdy, rrsp_vld, rrsp_data, rrsp_err, wreq_rdy,
        output vread, vrdaddr, vwrite, vwraddr, vdin, seq_err
    );

    // Environment view (clients plus core)
    modport master (
        output rreq_vld, rreq_addr, wreq_vld, wreq_addr, wreq_data,
        output vread_vld, vdout, vread_err, ready,
        input  rreq_rdy, rrsp_vld, rrsp_data, rrsp_err, wreq_rdy,
        input  vread, vrdaddr, vwrite, vwraddr, vdin, seq_err
    );

endinterface

// File: rtl/rr_arb.sv
// Round-robin arbiter: one-hot grant, search starts after the last granted client.
module rr_arb
    import arb_1r1w_pkg::*;
#(
    parameter int N    = 4,
    parameter int BITN = 2
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [N-1:0]    req,
    input  logic            en,
    output logic [N-1:0]    gnt,
    output logic [BITN-1:0] gnt_id
);

    logic [BITN-1:0] ptr_q;
    logic [BITN-1:0] ptr_d;
    logic [BITN-1:0] cand;
    logic            found;

    // Priority search from ptr+1, wrapping, first requester wins.
    always_comb begin
        gnt    = '0;
        gnt_id = '0;
        found  = 1'b0;
        cand   = '0;
        for (int k = 1; k <= N; k++) begin
            if ((int'(ptr_q) + k) >= N) begin
                cand = BITN'(int'(ptr_q) + k - N);
            end else begin
                cand = BITN'(int'(ptr_q) + k);
            end
            if (en && !found && req[cand]) begin
                gnt[cand] = 1'b1;
                gnt_id    = cand;
                found     = 1'b1;
            end
        end
    end

    // Pointer moves to the granted client only when an accept happens.
    always_comb begin
        ptr_d = found ? gnt_id : ptr_q;
    end

    // Pointer register; reset to the last client so client 0 wins first.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ptr_q <= BITN'(N - 1);
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/arb_1r1w_a1.sv
// Multi-client front-end for the 1R1W core: RR arbitration, issue registers,
// read-tag pipeline, response demux and sequence checking.
module arb_1r1w_a1
    import arb_1r1w_pkg::*;
#(
    parameter int WIDTH      = 32,
    parameter int BITADDR    = 13,
    parameter int NUMRCLI    = 4,
    parameter int BITRCLI    = 2,
    parameter int NUMWCLI    = 2,
    parameter int BITWCLI    = 1,
    parameter int SRAM_DELAY = 2
) (
    input  logic          clk,
    input  logic          rst,
    arb_1r1w_a1_if.slave  bus
);

    // Stage 0 lines up with vread; the last stage lines up with vread_vld,
    // which arrives SRAM_DELAY cycles after vread.
    localparam int TAG_DEPTH = SRAM_DELAY + 1;

    logic                grant_en;
    logic [NUMRCLI-1:0]  rgnt;
    logic [BITRCLI-1:0]  rgnt_id;
    logic [NUMWCLI-1:0]  wgnt;
    logic [BITWCLI-1:0]  wgnt_id;

    logic [BITADDR-1:0]  raddr_arr [NUMRCLI];
    logic [BITADDR-1:0]  waddr_arr [NUMWCLI];
    logic [WIDTH-1:0]    wdata_arr [NUMWCLI];

    logic                vread_q,   vread_d;
    logic [BITADDR-1:0]  vrdaddr_q, vrdaddr_d;
    logic                vwrite_q,  vwrite_d;
    logic [BITADDR-1:0]  vwraddr_q, vwraddr_d;
    logic [WIDTH-1:0]    vdin_q,    vdin_d;

    tag_t                tag_q [TAG_DEPTH];
    tag_t                tag_d [TAG_DEPTH];
    tag_t                tag_tail;

    logic                seq_err_q, seq_err_d;

    // Grants are suppressed while the core is busy or reset is held.
    assign grant_en = bus.ready & rst;

    rr_arb #(.N(NUMRCLI), .BITN(BITRCLI)) u_rd_arb (
        .clk    (clk),
        .rst    (rst),
        .req    (bus.rreq_vld),
        .en     (grant_en),
        .gnt    (rgnt),
        .gnt_id (rgnt_id)
    );

    rr_arb #(.N(NUMWCLI), .BITN(BITWCLI)) u_wr_arb (
        .clk    (clk),
        .rst    (rst),
        .req    (bus.wreq_vld),
        .en     (grant_en),
        .gnt    (wgnt),
        .gnt_id (wgnt_id)
    );

    assign bus.rreq_rdy = rgnt;
    assign bus.wreq_rdy = wgnt;

    // Unpack the flat per-client address/data buses.
    generate
        for (genvar gi = 0; gi < NUMRCLI; gi++) begin : g_rd_unpack
            assign raddr_arr[gi] = bus.rreq_addr[gi*BITADDR +: BITADDR];
        end
        for (genvar gi = 0; gi < NUMWCLI; gi++) begin : g_wr_unpack
            assign waddr_arr[gi] = bus.wreq_addr[gi*BITADDR +: BITADDR];
            assign wdata_arr[gi] = bus.wreq_data[gi*WIDTH +: WIDTH];
        end
    endgenerate

    // Next issue values: valid follows the accept, address/data hold when idle.
    always_comb begin
        vread_d   = |rgnt;
        vrdaddr_d = vrdaddr_q;
        vwrite_d  = |wgnt;
        vwraddr_d = vwraddr_q;
        vdin_d    = vdin_q;
        if (|rgnt) begin
            vrdaddr_d = raddr_arr[rgnt_id];
        end
        if (|wgnt) begin
            vwraddr_d = waddr_arr[wgnt_id];
            vdin_d    = wdata_arr[wgnt_id];
        end
    end

    // Issue registers driving the core request ports.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            vread_q   <= 1'b0;
            vrdaddr_q <= '0;
            vwrite_q  <= 1'b0;
            vwraddr_q <= '0;
            vdin_q    <= '0;
        end else begin
            vread_q   <= vread_d;
            vrdaddr_q <= vrdaddr_d;
            vwrite_q  <= vwrite_d;
            vwraddr_q <= vwraddr_d;
            vdin_q    <= vdin_d;
        end
    end

    assign bus.vread   = vread_q;
    assign bus.vrdaddr = vrdaddr_q;
    assign bus.vwrite  = vwrite_q;
    assign bus.vwraddr = vwraddr_q;
    assign bus.vdin    = vdin_q;

    // Tag shift chain: stage 0 captures the read being issued, others shift.
    always_comb begin
        tag_d[0].vld = vread_d;
        tag_d[0].id  = MAX_CLI_BITS'(rgnt_id);
        for (int i = 1; i < TAG_DEPTH; i++) begin
            tag_d[i] = tag_q[i-1];
        end
    end

    // Tag pipeline registers; reset drops any reads in flight.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < TAG_DEPTH; i++) begin
                tag_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < TAG_DEPTH; i++) begin
                tag_q[i] <= tag_d[i];
            end
        end
    end

    assign tag_tail = tag_q[TAG_DEPTH-1];

    // Response demux: strobe only the client whose tag matches a real response.
    generate
        for (genvar gi = 0; gi < NUMRCLI; gi++) begin : g_rsp_demux
            assign bus.rrsp_vld[gi] = bus.vread_vld & tag_tail.vld &
                                      (tag_tail.id == MAX_CLI_BITS'(gi));
        end
    endgenerate

    assign bus.rrsp_data = bus.vdout;
    assign bus.rrsp_err  = bus.vread_err;

    // Sticky flag: core response and tag tail disagree.
    always_comb begin
        seq_err_d = seq_err_q | (bus.vread_vld != tag_tail.vld);
    end

    // Sequence-error register, cleared only by reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            seq_err_q <= 1'b0;
        end else begin
            seq_err_q <= seq_err_d;
        end
    end

    assign bus.seq_err = seq_err_q;

endmodule

// File: tb/tb_arb_1r1w_a1.sv
// Directed bench for arb_1r1w_a1 with a small behavioural 1R1W core model.
module tb_arb_1r1w_a1;

    localparam int WIDTH      = 32;
    localparam int BITADDR    = 13;
    localparam int NUMRCLI    = 4;
    localparam int BITRCLI    = 2;
    localparam int NUMWCLI    = 2;
    localparam int BITWCLI    = 1;
    localparam int SRAM_DELAY = 2;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic inject = 1'b0;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    arb_1r1w_a1_if #(.WIDTH(WIDTH), .BITADDR(BITADDR),
                     .NUMRCLI(NUMRCLI), .NUMWCLI(NUMWCLI)) bus ();

    arb_1r1w_a1 #(
        .WIDTH(WIDTH), .BITADDR(BITADDR), .NUMRCLI(NUMRCLI), .BITRCLI(BITRCLI),
        .NUMWCLI(NUMWCLI), .BITWCLI(BITWCLI), .SRAM_DELAY(SRAM_DELAY)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Core model: memory preset to 0xA000_0000|addr on reset, fixed read latency.
    logic [WIDTH-1:0]      mem [0:(1<<BITADDR)-1];
    logic [SRAM_DELAY-1:0] pv;
    logic [WIDTH-1:0]      pd [SRAM_DELAY];

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < (1 << BITADDR); i++) mem[i] <= 32'hA000_0000 | i;
            pv <= '0;
            for (int i = 0; i < SRAM_DELAY; i++) pd[i] <= '0;
        end else begin
            pv[0] <= bus.vread;
            pd[0] <= mem[bus.vrdaddr];
            for (int i = 1; i < SRAM_DELAY; i++) begin
                pv[i] <= pv[i-1];
                pd[i] <= pd[i-1];
            end
            if (bus.vwrite) mem[bus.vwraddr] <= bus.vdin;
        end
    end

    assign bus.vread_vld = pv[SRAM_DELAY-1] | inject;
    assign bus.vdout     = pd[SRAM_DELAY-1];
    assign bus.vread_err = 1'b0;

    task automatic clear_reqs();
        bus.rreq_vld = '0;
        bus.wreq_vld = '0;
    endtask

    task automatic do_reset();
        clear_reqs();
        rst = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_reset();
        bus.ready    = 1'b1;
        bus.rreq_vld = 4'hF;
        bus.wreq_vld = 2'b11;
        rst = 1'b0;
        @(negedge clk); #1;
        n_cmp++; if (bus.rreq_rdy !== 4'b0) begin n_err++; $display("FAIL rst_rreq_rdy: got %b want 0000", bus.rreq_rdy); end
        n_cmp++; if (bus.wreq_rdy !== 2'b0) begin n_err++; $display("FAIL rst_wreq_rdy: got %b want 00", bus.wreq_rdy); end
        n_cmp++; if (bus.rrsp_vld !== 4'b0) begin n_err++; $display("FAIL rst_rrsp_vld: got %b want 0000", bus.rrsp_vld); end
        n_cmp++; if (bus.vread !== 1'b0) begin n_err++; $display("FAIL rst_vread: got %b want 0", bus.vread); end
        n_cmp++; if (bus.vwrite !== 1'b0) begin n_err++; $display("FAIL rst_vwrite: got %b want 0", bus.vwrite); end
        n_cmp++; if (bus.vrdaddr !== 13'h0) begin n_err++; $display("FAIL rst_vrdaddr: got %h want 0", bus.vrdaddr); end
        n_cmp++; if (bus.vwraddr !== 13'h0) begin n_err++; $display("FAIL rst_vwraddr: got %h want 0", bus.vwraddr); end
        n_cmp++; if (bus.vdin !== 32'h0) begin n_err++; $display("FAIL rst_vdin: got %h want 0", bus.vdin); end
        n_cmp++; if (bus.seq_err !== 1'b0) begin n_err++; $display("FAIL rst_seq_err: got %b want 0", bus.seq_err); end
        clear_reqs();
        rst = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_write_read();
        bus.wreq_vld  = 2'b10;
        bus.wreq_addr = {13'h0A5, 13'h000};
        bus.wreq_data = {32'hDEADBEEF, 32'h0};
        #1;
        n_cmp++; if (bus.wreq_rdy !== 2'b10) begin n_err++; $display("FAIL wr_grant: got %b want 10", bus.wreq_rdy); end
        @(negedge clk);
        n_cmp++; if (bus.vwrite !== 1'b1) begin n_err++; $display("FAIL wr_issue: got %b want 1", bus.vwrite); end
        n_cmp++; if (bus.vwraddr !== 13'h0A5) begin n_err++; $display("FAIL wr_addr: got %h want 0a5", bus.vwraddr); end
        n_cmp++; if (bus.vdin !== 32'hDEADBEEF) begin n_err++; $display("FAIL wr_data: got %h want deadbeef", bus.vdin); end
        bus.wreq_vld  = 2'b00;
        bus.rreq_addr = '0;
        bus.rreq_addr[2*BITADDR +: BITADDR] = 13'h0A5;
        bus.rreq_vld  = 4'b0100;
        #1;
        n_cmp++; if (bus.rreq_rdy !== 4'b0100) begin n_err++; $display("FAIL rd_grant: got %b want 0100", bus.rreq_rdy); end
        for (int k = 1; k <= 1 + SRAM_DELAY; k++) begin
            @(negedge clk);
            if (k == 1) begin
                bus.rreq_vld = '0;
                n_cmp++; if (bus.vread !== 1'b1 || bus.vrdaddr !== 13'h0A5) begin n_err++; $display("FAIL rd_issue: got vread=%b addr=%h want 1/0a5", bus.vread, bus.vrdaddr); end
            end
            if (k == 1 + SRAM_DELAY) begin
                n_cmp++; if (bus.rrsp_vld !== 4'b0100) begin n_err++; $display("FAIL rd_rsp_vld: got %b want 0100", bus.rrsp_vld); end
                n_cmp++; if (bus.rrsp_data !== 32'hDEADBEEF || bus.rrsp_err !== 1'b0) begin n_err++; $display("FAIL rd_rsp_data: got %h err %b want deadbeef err 0", bus.rrsp_data, bus.rrsp_err); end
                $display("rd rsp strobe %b data %h", bus.rrsp_vld, bus.rrsp_data);
            end else begin
                n_cmp++; if (bus.rrsp_vld !== 4'b0000) begin n_err++; $display("FAIL rd_rsp_early k=%0d: got %b want 0000", k, bus.rrsp_vld); end
            end
        end
    endtask

    task automatic test_round_robin();
        logic [3:0]       exp_vld;
        logic [WIDTH-1:0] exp_data;
        int               cli;
        do_reset();
        for (int i = 0; i < NUMRCLI; i++) bus.rreq_addr[i*BITADDR +: BITADDR] = 13'(32'h100 + i);
        for (int c = 0; c < 11; c++) begin
            @(negedge clk);
            if (c >= 3 && c - 3 < 8) begin
                cli      = (c - 3) % 4;
                exp_vld  = 4'(1 << cli);
                exp_data = 32'hA000_0100 | cli;
                $display("rr rsp cycle %0d strobe %b data %h", c, bus.rrsp_vld, bus.rrsp_data);
            end else begin
                exp_vld  = 4'b0;
                exp_data = bus.rrsp_data;
            end
            n_cmp++; if (bus.rrsp_vld !== exp_vld) begin n_err++; $display("FAIL rr_rsp_vld c=%0d: got %b want %b", c, bus.rrsp_vld, exp_vld); end
            if (exp_vld != 4'b0) begin
                n_cmp++; if (bus.rrsp_data !== exp_data) begin n_err++; $display("FAIL rr_rsp_data c=%0d: got %h want %h", c, bus.rrsp_data, exp_data); end
            end
            bus.rreq_vld = (c < 8) ? 4'hF : 4'h0;
            #1;
            if (c < 8) begin
                n_cmp++; if (bus.rreq_rdy !== 4'(1 << (c % 4))) begin n_err++; $display("FAIL rr_grant c=%0d: got %b want %b", c, bus.rreq_rdy, 4'(1 << (c % 4))); end
            end
        end
    endtask

    task automatic test_same_cycle();
        @(negedge clk);
        bus.rreq_addr[0 +: BITADDR] = 13'h010;
        bus.wreq_addr = {13'h0A5, 13'h020};
        bus.wreq_data = {32'hDEADBEEF, 32'h12345678};
        bus.rreq_vld  = 4'b0001;
        bus.wreq_vld  = 2'b01;
        #1;
        n_cmp++; if (bus.rreq_rdy !== 4'b0001 || bus.wreq_rdy !== 2'b01) begin n_err++; $display("FAIL sc_grant: got r=%b w=%b want 0001/01", bus.rreq_rdy, bus.wreq_rdy); end
        @(negedge clk);
        n_cmp++; if (bus.vread !== 1'b1 || bus.vrdaddr !== 13'h010) begin n_err++; $display("FAIL sc_vread: got %b/%h want 1/010", bus.vread, bus.vrdaddr); end
        n_cmp++; if (bus.vwrite !== 1'b1 || bus.vwraddr !== 13'h020 || bus.vdin !== 32'h12345678) begin n_err++; $display("FAIL sc_vwrite: got %b/%h/%h want 1/020/12345678", bus.vwrite, bus.vwraddr, bus.vdin); end
        // Both pointers now sit at 0, so client 1 must win a 0-vs-1 contest.
        bus.rreq_vld = 4'b0011;
        bus.wreq_vld = 2'b11;
        #1;
        n_cmp++; if (bus.rreq_rdy !== 4'b0010) begin n_err++; $display("FAIL sc_rptr: got %b want 0010", bus.rreq_rdy); end
        n_cmp++; if (bus.wreq_rdy !== 2'b10) begin n_err++; $display("FAIL sc_wptr: got %b want 10", bus.wreq_rdy); end
        @(negedge clk);
        clear_reqs();
        repeat (4) @(negedge clk);
    endtask

    task automatic test_ready_gate();
        do_reset();
        bus.ready = 1'b0;
        bus.rreq_addr[0 +: BITADDR] = 13'h055;
        bus.rreq_vld = 4'hF;
        bus.wreq_vld = 2'b11;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk); #1;
            n_cmp++; if (bus.rreq_rdy !== 4'b0 || bus.wreq_rdy !== 2'b0) begin n_err++; $display("FAIL rdy_gate c=%0d: got r=%b w=%b want 0/0", c, bus.rreq_rdy, bus.wreq_rdy); end
            n_cmp++; if (bus.vread !== 1'b0 || bus.vwrite !== 1'b0) begin n_err++; $display("FAIL rdy_issue c=%0d: got %b/%b want 0/0", c, bus.vread, bus.vwrite); end
        end
        @(negedge clk);
        bus.ready = 1'b1;
        #1;
        n_cmp++; if (bus.rreq_rdy !== 4'b0001 || bus.wreq_rdy !== 2'b01) begin n_err++; $display("FAIL rdy_first: got r=%b w=%b want 0001/01", bus.rreq_rdy, bus.wreq_rdy); end
        for (int k = 1; k <= 1 + SRAM_DELAY; k++) begin
            @(negedge clk);
            if (k == 1) begin
                // Drop ready right after the accept; the issued read must still return.
                bus.ready = 1'b0;
                clear_reqs();
                n_cmp++; if (bus.vread !== 1'b1 || bus.vwrite !== 1'b1) begin n_err++; $display("FAIL rdy_issue_up: got %b/%b want 1/1", bus.vread, bus.vwrite); end
            end
        end
        n_cmp++; if (bus.rrsp_vld !== 4'b0001 || bus.rrsp_data !== 32'hA000_0055) begin n_err++; $display("FAIL rdy_drain: got %b/%h want 0001/a0000055", bus.rrsp_vld, bus.rrsp_data); end
        bus.ready = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_reset_inflight();
        do_reset();
        bus.rreq_addr[0 +: BITADDR]       = 13'h030;
        bus.rreq_addr[BITADDR +: BITADDR] = 13'h031;
        bus.rreq_vld = 4'b0001;
        @(negedge clk);
        bus.rreq_vld = 4'b0010;
        @(negedge clk);
        clear_reqs();
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            n_cmp++; if (bus.rrsp_vld !== 4'b0) begin n_err++; $display("FAIL inflight_rsp c=%0d: got %b want 0000", c, bus.rrsp_vld); end
            n_cmp++; if (bus.seq_err !== 1'b0) begin n_err++; $display("FAIL inflight_seq c=%0d: got %b want 0", c, bus.seq_err); end
        end
        bus.rreq_vld = 4'hF;
        bus.wreq_vld = 2'b11;
        #1;
        n_cmp++; if (bus.rreq_rdy !== 4'b0001 || bus.wreq_rdy !== 2'b01) begin n_err++; $display("FAIL inflight_ptr: got r=%b w=%b want 0001/01", bus.rreq_rdy, bus.wreq_rdy); end
        @(negedge clk);
        clear_reqs();
        repeat (4) @(negedge clk);
    endtask

    task automatic test_seq_err();
        n_cmp++; if (bus.seq_err !== 1'b0) begin n_err++; $display("FAIL seq_base: got %b want 0", bus.seq_err); end
        inject = 1'b1;
        #1;
        n_cmp++; if (bus.rrsp_vld !== 4'b0) begin n_err++; $display("FAIL seq_rsp: got %b want 0000", bus.rrsp_vld); end
        @(negedge clk);
        inject = 1'b0;
        for (int c = 0; c < 4; c++) begin
            n_cmp++; if (bus.seq_err !== 1'b1) begin n_err++; $display("FAIL seq_sticky c=%0d: got %b want 1", c, bus.seq_err); end
            @(negedge clk);
        end
        rst = 1'b0;
        #1;
        n_cmp++; if (bus.seq_err !== 1'b0) begin n_err++; $display("FAIL seq_clear: got %b want 0", bus.seq_err); end
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: bench did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        bus.ready     = 1'b0;
        bus.rreq_vld  = '0;
        bus.rreq_addr = '0;
        bus.wreq_vld  = '0;
        bus.wreq_addr = '0;
        bus.wreq_data = '0;
        #1;
        test_reset();
        test_write_read();
        test_round_robin();
        test_same_cycle();
        test_ready_gate();
        test_reset_inflight();
        test_seq_err();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
